fa_using_ha: RTL and testbench
==============================

Name: fa_using_ha

Overview:
- Registered ripple-carry adder built strictly from half-adder cells. Each bit is two half adders plus an OR for carry-out.
- WIDTH=1 (default) gives a single-bit full adder with a 1-cycle registered output.
- Used as the basic arithmetic leaf in datapaths that need a clocked adder with a valid qualifier.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle; result register loads only when 1
- a  input  WIDTH  operand A (unsigned; two's-complement when overflow feature enabled)
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out of MSB
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Per bit i, combinational:
  - ha0: s0 = a[i]^b[i], c0 = a[i]&b[i].
  - ha1: s[i] = s0^c[i], c1 = s0&c[i].
  - c[i+1] = c0|c1, with c[0] = cin.
- No `+` operator for the datapath; the adder must be composed of half-adder instances.
- Result: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1), i.e. exact, with no loss.
- Latency: 1 clock. Operands sampled at posedge k with in_valid=1 appear on sum/cout at posedge k and are stable during cycle k+1.
- out_valid <= in_valid every non-reset edge.
- in_valid=0: sum/cout hold their previous value; out_valid goes 0.
- Reset (rst=1 at posedge): sum=0, cout=0, out_valid=0. Reset has priority over in_valid on the same edge.
- Reset asserted mid-stream: the next edge clears all outputs; the first valid after rst deasserts returns its result 1 cycle later as normal.
- WIDTH=1 truth table (a,b,cin -> cout,sum):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- No X propagation from the held registers; outputs are 0 before the first valid result after reset.

Optional Feature:
- Macro FA_USING_HA_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered with sum).
  - ovf = c[WIDTH] ^ c[WIDTH-1], the signed two's-complement overflow.
  - Reset value 0; holds when in_valid=0.
  - For WIDTH=1, c[0] is cin.
- Undefined:
  - Port ovf does not exist.
  - No overflow logic is synthesized.

Decomposition:
- Package fa_using_ha_pkg holds:
  - localparam FA_MAX_WIDTH = 64.
  - typedef struct packed {logic s; logic c;} ha_out_t.
  - Reset constants for the output registers.
- One sub-module: ha_cell (inputs x, y; outputs s = x^y, c = x&y, purely combinational).
- Instantiate ha_cell 2*WIDTH times via a generate loop; the per-bit carry OR and all registers stay in fa_using_ha.

Test Plan:
1. WIDTH=1, reset then apply all 8 (a,b,cin) combos with in_valid=1, one every 10 time units in ascending order (000..111) -> each cycle-later output matches the truth table, e.g. 111 -> cout=1, sum=1; 011 -> cout=1, sum=0.
2. WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> next cycle sum=8'h00, cout=1, out_valid=1. Also a=8'hA5, b=8'h5A, cin=0 -> sum=8'hFF, cout=0.
3. Hold: load a=3, b=4, cin=0 at WIDTH=8 (sum=7), then in_valid=0 for 3 cycles with operands changing -> sum stays 7, cout 0, out_valid 0.
4. Reset priority: rst=1 and in_valid=1 on the same edge with a=b=8'hFF -> sum=0, cout=0, out_valid=0. Then deassert rst with a=1, b=1, cin=1 -> sum=3 after 1 cycle.
5. FA_USING_HA_OVF_EN, WIDTH=8:
   - 8'h7F+8'h01, cin=0 -> sum=8'h80, ovf=1, cout=0.
   - 8'hFF+8'h01 -> sum=0, ovf=0, cout=1.
6. Random WIDTH=16, 1000 vectors with random in_valid -> {cout,sum} equals the golden a+b+cin delayed 1 cycle, held on invalid cycles.

Source files
------------

// File: rtl/fa_using_ha_pkg.sv
// ============================================================================
// Module   : fa_using_ha_pkg
// Brief    : Shared types and reset constants for the half-adder based adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fa_using_ha_pkg;

    localparam int FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic s;
        logic c;
    } ha_out_t;

    localparam logic [FA_MAX_WIDTH-1:0] c_RST_SUM   = '0;
    localparam logic                    c_RST_COUT  = 1'b0;
    localparam logic                    c_RST_VALID = 1'b0;
    localparam logic                    c_RST_OVF   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/fa_using_ha_ha_cell.sv
// ============================================================================
// Module   : ha_cell
// Brief    : Combinational half adder, s = x ^ y, c = x & y.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

`default_nettype wire

// File: rtl/fa_using_ha.sv
// ============================================================================
// Module   : fa_using_ha
// Brief    : Registered ripple-carry adder built from half-adder cells, with
//            optional signed overflow output (macro FA_USING_HA_OVF_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_using_ha
    import fa_using_ha_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef FA_USING_HA_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]            w_c;
    logic [WIDTH-1:0]          w_s;
    ha_out_t [WIDTH-1:0]       w_ha0;
    ha_out_t [WIDTH-1:0]       w_ha1;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            ha_cell u_ha0 (
                .x (a[i]),
                .y (b[i]),
                .s (w_ha0[i].s),
                .c (w_ha0[i].c)
            );
            ha_cell u_ha1 (
                .x (w_ha0[i].s),
                .y (w_c[i]),
                .s (w_ha1[i].s),
                .c (w_ha1[i].c)
            );
            assign w_s[i]   = w_ha1[i].s;
            assign w_c[i+1] = w_ha0[i].c | w_ha1[i].c;
        end
    endgenerate

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q;

    // Result registers hold across invalid cycles; only out_valid follows in_valid.
    assign sum_d  = in_valid ? w_s        : sum_q;
    assign cout_d = in_valid ? w_c[WIDTH] : cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= c_RST_SUM[WIDTH-1:0];
            cout_q      <= c_RST_COUT;
            out_valid_q <= c_RST_VALID;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef FA_USING_HA_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = in_valid ? (w_c[WIDTH] ^ w_c[WIDTH-1]) : ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= c_RST_OVF;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fa_using_ha.sv
// ============================================================================
// Module   : tb_fa_using_ha
// Brief    : Self-checking bench for fa_using_ha at WIDTH = 1, 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fa_using_ha;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic live = 1'b0;
    always #5 clk = ~clk;

    logic        v1, a1, b1, c1, s1, co1, vo1;
    logic        v8, c8, co8, vo8;
    logic [7:0]  a8, b8, s8;
    logic        v16, c16, co16, vo16;
    logic [15:0] a16, b16, s16;
`ifdef FA_USING_HA_OVF_EN
    logic        of1, of8, of16;
`endif

    int n_vec = 0;
    int n_err = 0;

    fa_using_ha #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .out_valid(vo1)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(of1)
`endif
    );

    fa_using_ha #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .out_valid(vo8)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(of8)
`endif
    );

    fa_using_ha #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .sum(s16), .cout(co16), .out_valid(vo16)
`ifdef FA_USING_HA_OVF_EN
        , .ovf(of16)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden result from plain integer arithmetic, signed range test for overflow.
    function automatic res_t gold(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input res_t prev);
        res_t r;
        longint unsigned t;
        longint lim, sa, sb, st;
        r   = prev;
        t   = a + b + 64'(ci);
        r.s = t & ((64'd1 << w) - 64'd1);
        r.co = ((t >> w) & 64'd1) != 0;
        lim = longint'(1) << (w - 1);
        sa  = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb  = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
        st  = sa + sb + longint'(ci);
        r.ov = (st >= lim) || (st < -lim);
        return r;
    endfunction

    res_t m1, m8, m16;
    localparam res_t c_ZERO = '{s: 64'd0, co: 1'b0, ov: 1'b0, v: 1'b0};

    always @(posedge clk) begin
        if (rst) begin
            m1 = c_ZERO; m8 = c_ZERO; m16 = c_ZERO;
        end else begin
            if (v1)  m1  = gold(1,  64'(a1),  64'(b1),  c1,  m1);
            if (v8)  m8  = gold(8,  64'(a8),  64'(b8),  c8,  m8);
            if (v16) m16 = gold(16, 64'(a16), 64'(b16), c16, m16);
            m1.v = v1; m8.v = v8; m16.v = v16;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("m1_sum",    64'(s1),   m1.s);
            check("m1_cout",   64'(co1),  64'(m1.co));
            check("m1_valid",  64'(vo1),  64'(m1.v));
            check("m8_sum",    64'(s8),   m8.s);
            check("m8_cout",   64'(co8),  64'(m8.co));
            check("m8_valid",  64'(vo8),  64'(m8.v));
            check("m16_sum",   64'(s16),  m16.s);
            check("m16_cout",  64'(co16), 64'(m16.co));
            check("m16_valid", 64'(vo16), 64'(m16.v));
`ifdef FA_USING_HA_OVF_EN
            check("m1_ovf",    64'(of1),  64'(m1.ov));
            check("m8_ovf",    64'(of8),  64'(m8.ov));
            check("m16_ovf",   64'(of16), 64'(m16.ov));
`endif
        end
    end

    task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        a8 = a; b8 = b; c8 = c; v8 = v;
        @(posedge clk); #1;
    endtask

    logic [1:0] tt [8];
    logic [2:0] idx;

    initial begin
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        {v1, a1, b1, c1} = '0;
        {v8, a8, b8, c8} = '0;
        {v16, a16, b16, c16} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        live = 1'b1;
        check("rst_sum8",   64'(s8),  64'h0);
        check("rst_cout8",  64'(co8), 64'h0);
        check("rst_valid8", 64'(vo8), 64'h0);
        check("rst_sum16",  64'(s16), 64'h0);
        rst = 1'b0;

        // WIDTH=1 truth table, ascending
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {a1, b1, c1} = idx;
            v1 = 1'b1;
            @(posedge clk); #1;
            check("tt_coutsum", 64'({co1, s1}), 64'(tt[i]));
            check("tt_valid",   64'(vo1), 64'h1);
        end
        v1 = 1'b0;

        apply8(8'hFF, 8'h00, 1'b1, 1'b1);
        check("ff_sum",   64'(s8),  64'h00);
        check("ff_cout",  64'(co8), 64'h1);
        check("ff_valid", 64'(vo8), 64'h1);
        apply8(8'hA5, 8'h5A, 1'b0, 1'b1);
        check("a5_sum",  64'(s8),  64'hFF);
        check("a5_cout", 64'(co8), 64'h0);

        apply8(8'd3, 8'd4, 1'b0, 1'b1);
        check("hold_load", 64'(s8), 64'd7);
        for (int i = 0; i < 3; i++) begin
            apply8(8'(8'h10 + i), 8'hF0, 1'b1, 1'b0);
            check("hold_sum",   64'(s8),  64'd7);
            check("hold_cout",  64'(co8), 64'h0);
            check("hold_valid", 64'(vo8), 64'h0);
        end

        rst = 1'b1;
        apply8(8'hFF, 8'hFF, 1'b0, 1'b1);
        check("rp_sum",   64'(s8),  64'h0);
        check("rp_cout",  64'(co8), 64'h0);
        check("rp_valid", 64'(vo8), 64'h0);
        rst = 1'b0;
        apply8(8'd1, 8'd1, 1'b1, 1'b1);
        check("post_rst_sum",   64'(s8),  64'd3);
        check("post_rst_valid", 64'(vo8), 64'h1);

`ifdef FA_USING_HA_OVF_EN
        apply8(8'h7F, 8'h01, 1'b0, 1'b1);
        check("ovf_pos_sum",  64'(s8),  64'h80);
        check("ovf_pos_ovf",  64'(of8), 64'h1);
        check("ovf_pos_cout", 64'(co8), 64'h0);
        apply8(8'hFF, 8'h01, 1'b0, 1'b1);
        check("ovf_wrap_sum",  64'(s8),  64'h00);
        check("ovf_wrap_ovf",  64'(of8), 64'h0);
        check("ovf_wrap_cout", 64'(co8), 64'h1);
`endif
        v8 = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            v16 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        v16 = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
